// File: rtl/debug_reg_dump.sv
// Debug register dump: sweeps the register file debug read port and streams each word LSB-byte first.
// Optional DEBUG_REG_DUMP_CHECKSUM_EN appends an XOR checksum byte after the last register.
module debug_reg_dump #(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int NB_BYTE  = 8,
    parameter int SIZE_REG = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic [NB_REG-1:0]  o_address_read_debug,
    input  logic [NB_DATA-1:0] i_data_read_debug,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SET_ADDR = 3'd1;
    localparam logic [2:0] S_LATCH    = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_CKSUM    = 3'd5;

    localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(SIZE_REG - 1);
    localparam logic [1:0]        LAST_IDX  = 2'(NB_DATA / NB_BYTE - 1);

    logic [2:0]         state_q, state_d;
    logic [NB_REG-1:0]  addr_q, addr_d;
    logic [1:0]         idx_q, idx_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               xfer;

`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] cksum_q, cksum_d;
`endif

    assign xfer = o_tx_valid & i_tx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
        cksum_d = cksum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    idx_d   = '0;
                    state_d = S_SET_ADDR;
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
            // Address is presented here; read data is valid one cycle later in LATCH.
            S_SET_ADDR: state_d = S_LATCH;
            S_LATCH: begin
                shift_d = i_data_read_debug;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
                    cksum_d = cksum_q ^ shift_q[NB_BYTE-1:0];
`endif
                    if (idx_q != LAST_IDX) begin
                        shift_d = shift_q >> NB_BYTE;
                        idx_d   = idx_q + 2'd1;
                    end else if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        idx_d   = '0;
                        state_d = S_SET_ADDR;
                    end else begin
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
            S_CKSUM: begin
                if (xfer) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
            cksum_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    assign o_address_read_debug = addr_q;
    assign o_busy               = (state_q != S_IDLE);
    assign o_done               = (state_q == S_DONE);

`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
    assign o_tx_valid = (state_q == S_SEND) || (state_q == S_CKSUM);
    assign o_tx_data  = (state_q == S_CKSUM) ? cksum_q : shift_q[NB_BYTE-1:0];
`else
    assign o_tx_valid = (state_q == S_SEND);
    assign o_tx_data  = shift_q[NB_BYTE-1:0];
`endif

endmodule

// File: tb/tb_debug_reg_dump.sv
// Scoreboard bench for debug_reg_dump: expected bytes are queued at stimulus time and
// popped by an independent monitor on every observed byte transfer.
module tb_debug_reg_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  addr;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  exp_data [$];
    logic [4:0]  exp_addr [$];

    int   errors = 0;
    int   checks = 0;
    int   n_xfer = 0;
    bit   rand_ready = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] got_d;
    logic [4:0] got_a;

`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
    localparam int EXP_CYC = 193;
`else
    localparam int EXP_CYC = 192;
`endif

    debug_reg_dump dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_start              (start),
        .o_address_read_debug (addr),
        .i_data_read_debug    (rdata),
        .o_tx_data            (tx_data),
        .o_tx_valid           (tx_valid),
        .i_tx_ready           (tx_ready),
        .o_busy               (busy),
        .o_done               (done)
    );

    initial forever #5 clk = ~clk;

    // Register file model: one-cycle read latency.
    always @(posedge clk) rdata <= regs[addr];

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every transfer against the scoreboard and checks hold-under-stall.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %h expected no byte", tx_data);
                end else begin
                    got_d = exp_data.pop_front();
                    got_a = exp_addr.pop_front();
                    check("byte", {24'd0, tx_data}, {24'd0, got_d});
                    check("byte_addr", {27'd0, addr}, {27'd0, got_a});
                end
                n_xfer++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic push_dump(input bit use_ck, input logic [7:0] ck);
        logic [7:0] x;
        x = '0;
        for (int w = 0; w < 32; w++) begin
            for (int b = 0; b < 4; b++) begin
                exp_data.push_back(regs[w][8*b +: 8]);
                exp_addr.push_back(5'(w));
                x ^= regs[w][8*b +: 8];
            end
        end
`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
        exp_data.push_back(use_ck ? ck : x);
        exp_addr.push_back(5'd31);
`endif
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the sampling edge until o_done is seen.
    task automatic run_dump(input string tag);
        int cycles, stalls, first;
        bit ok;
        cycles = 0; stalls = 0; first = -1; ok = 1'b0;
        start_pulse();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (tx_valid && first < 0) first = cycles;
            if (tx_valid && !tx_ready) stalls++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 3000 cycles", tag);
        end else begin
            check({tag, "_first_valid"}, first, 2);
            check({tag, "_cycles"}, cycles, EXP_CYC + stalls);
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
            check({tag, "_addr_at_done"}, {27'd0, addr}, 32'd31);
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
            check({tag, "_addr_held"}, {27'd0, addr}, 32'd31);
            check({tag, "_remaining"}, exp_data.size(), 0);
        end
    endtask

    task automatic wait_xfer(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (n_xfer >= n) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_xfer: got %0d transfers expected %0d", n_xfer, n);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA0B0C000 + i;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", {27'd0, addr}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic dump, ready held high.
        push_dump(1'b0, 8'h00);
        run_dump("basic");

        // Random backpressure with a distinct pattern.
        for (int i = 0; i < 32; i++) regs[i] = 32'h12345678 ^ (i * 32'h01010101);
        rand_ready = 1'b1;
        push_dump(1'b0, 8'h00);
        run_dump("stall");
        rand_ready = 1'b0;

        // Start re-pulsed at byte 50 is ignored.
        for (int i = 0; i < 32; i++) regs[i] = 32'hA0B0C000 + i;
        n_xfer = 0;
        push_dump(1'b0, 8'h00);
        fork
            run_dump("restart");
            begin
                wait_xfer(50);
                start_pulse();
            end
        join

        // Asynchronous reset during byte 70, then a fresh dump from address 0.
        n_xfer = 0;
        push_dump(1'b0, 8'h00);
        start_pulse();
        wait_xfer(70);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, tx_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_addr", {27'd0, addr}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_data", {24'd0, tx_data}, 32'd0);
        exp_data.delete();
        exp_addr.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_idle", {31'd0, busy}, 32'd0);
        push_dump(1'b0, 8'h00);
        run_dump("after_rst");

`ifdef DEBUG_REG_DUMP_CHECKSUM_EN
        for (int i = 0; i < 32; i++) regs[i] = 32'h01020304;
        push_dump(1'b1, 8'h00);
        run_dump("ck_even");
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[0] = 32'h000000FF;
        push_dump(1'b1, 8'hFF);
        run_dump("ck_ff");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
